// File: rtl/uart_hex_logger_pkg.sv
// Shared definitions for the hex record logger: ASCII constants,
// formatter state encoding and the nibble-to-ASCII helper.
package uart_hex_logger_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NIB  = 3'd1,
        ST_SEP  = 3'd2,
        ST_EOL1 = 3'd3,
        ST_EOL2 = 3'd4
    } state_t;

    // Upper-case hex digit for one nibble.
    function automatic logic [7:0] fnNib2ASCII(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/uart_hex_logger_fifo.sv
// Synchronous byte FIFO with show-ahead head and exact occupancy count.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [7:0]               din,
    input  logic                     rd,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign dout  = mem[rd_ptr];

    // A read is ignored when empty; a write while full is only taken
    // when the head is being freed in the same cycle.
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks net occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_hex_logger.sv
// Hex record formatter: turns a NUM_FIELDS x DATA_W record into an
// ASCII line, queues the bytes and paces them into the UART core.
module uart_hex_logger
    import uart_hex_logger_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_FIELDS = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned EOL_CRLF   = 1,
    parameter logic [7:0]  SEP_CHAR   = 8'h20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FIELDS*DATA_W-1:0] i_data,
    input  logic                         i_valid,
    input  logic                         i_suppress,
    output logic                         o_ready,
    output logic [7:0]                   o_tx_byte,
    output logic                         o_tx_stb,
    input  logic                         i_tx_active,
    output logic                         o_idle
);

    localparam int unsigned NIBS  = DATA_W / 4;
    localparam int unsigned REC_W = NUM_FIELDS * DATA_W;
    localparam int unsigned NW    = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int unsigned FW    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [NW-1:0] NIB_LAST = NW'(NIBS - 1);
    localparam logic [FW-1:0] FLD_LAST = FW'(NUM_FIELDS - 1);

    state_t          state;
    state_t          state_n;
    logic [REC_W-1:0] rec;
    logic            sup;
    logic            seen_nz;
    logic [NW-1:0]   nib;
    logic [FW-1:0]   fld;
    logic [3:0]      cur_nib;
    logic            accept;
    logic            skip;
    logic            step;
    logic            fifo_wr;
    logic            fifo_rd;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      wr_byte;
    logic [7:0]      fifo_dout;
    logic [CW-1:0]   fifo_cnt;

    // The latched record is shifted left as nibbles are consumed, so the
    // current nibble is always the top four bits.
    assign cur_nib = rec[REC_W-1 -: 4];
    assign o_ready = (state == ST_IDLE);
    assign accept  = i_valid & o_ready;
    assign fifo_rd = ~fifo_empty & ~i_tx_active & ~o_tx_stb;
    assign o_idle  = o_ready & (fifo_cnt == '0) & ~o_tx_stb & ~i_tx_active;

    // Next-state, byte selection and FIFO write decision.
    always_comb begin
        state_n = state;
        wr_byte = '0;
        skip    = 1'b0;
        fifo_wr = 1'b0;
        step    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_NIB;
                end
            end
            ST_NIB: begin
                wr_byte = fnNib2ASCII(cur_nib);
                skip    = sup & ~seen_nz & (cur_nib == 4'h0) & (nib != NIB_LAST);
                fifo_wr = ~fifo_full & ~skip;
                step    = skip | fifo_wr;
                if (step && (nib == NIB_LAST)) begin
                    state_n = (fld == FLD_LAST) ? ST_EOL1 : ST_SEP;
                end
            end
            ST_SEP: begin
                wr_byte = SEP_CHAR;
                fifo_wr = ~fifo_full;
                if (fifo_wr) begin
                    state_n = ST_NIB;
                end
            end
            ST_EOL1: begin
                wr_byte = (EOL_CRLF != 0) ? ASCII_CR : ASCII_LF;
                fifo_wr = ~fifo_full;
                if (fifo_wr) begin
                    state_n = (EOL_CRLF != 0) ? ST_EOL2 : ST_IDLE;
                end
            end
            ST_EOL2: begin
                wr_byte = ASCII_LF;
                fifo_wr = ~fifo_full;
                if (fifo_wr) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Record latch, field/nibble counters and leading-zero tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec     <= '0;
            sup     <= 1'b0;
            seen_nz <= 1'b0;
            nib     <= '0;
            fld     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rec     <= i_data;
                        sup     <= i_suppress;
                        seen_nz <= 1'b0;
                        nib     <= '0;
                        fld     <= '0;
                    end
                end
                ST_NIB: begin
                    if (step) begin
                        rec <= rec << 4;
                        nib <= (nib == NIB_LAST) ? '0 : nib + 1'b1;
                        if (fifo_wr && (cur_nib != 4'h0)) begin
                            seen_nz <= 1'b1;
                        end
                    end
                end
                ST_SEP: begin
                    if (fifo_wr) begin
                        fld     <= fld + 1'b1;
                        nib     <= '0;
                        seen_nz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobe pacing: the registered read keeps strobes at least one idle
    // cycle apart, hiding the UART's late is_transmitting.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tx_stb  <= 1'b0;
            o_tx_byte <= '0;
        end else begin
            o_tx_stb <= fifo_rd;
            if (fifo_rd) begin
                o_tx_byte <= fifo_dout;
            end
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (fifo_wr),
        .din   (wr_byte),
        .rd    (fifo_rd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

endmodule

// File: tb/tb_uart_hex_logger.sv
// Bench for uart_hex_logger: two configurations, a UART busy model and a
// byte scoreboard filled from a reference formatter as records are sent.
module tb_uart_hex_logger;

    localparam int BIT_CYC = 5;
    localparam int BUDGET  = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 2 x 32-bit fields, CR/LF, space separator, 4-deep FIFO.
    logic [63:0] a_data = '0;
    logic        a_valid = 1'b0;
    logic        a_sup = 1'b0;
    logic        a_ready, a_stb, a_idle, a_active;
    logic [7:0]  a_byte;
    logic        a_hold = 1'b0;
    int          a_busy = 0;

    // Instance B: 1 x 8-bit field, LF only, comma separator.
    logic [7:0]  b_data = '0;
    logic        b_valid = 1'b0;
    logic        b_sup = 1'b0;
    logic        b_ready, b_stb, b_idle, b_active;
    logic [7:0]  b_byte;
    int          b_busy = 0;

    uart_hex_logger #(
        .DATA_W(32), .NUM_FIELDS(2), .FIFO_DEPTH(4), .EOL_CRLF(1), .SEP_CHAR(8'h20)
    ) u_a (
        .clk(clk), .rst(rst), .i_data(a_data), .i_valid(a_valid), .i_suppress(a_sup),
        .o_ready(a_ready), .o_tx_byte(a_byte), .o_tx_stb(a_stb),
        .i_tx_active(a_active), .o_idle(a_idle)
    );

    uart_hex_logger #(
        .DATA_W(8), .NUM_FIELDS(1), .FIFO_DEPTH(16), .EOL_CRLF(0), .SEP_CHAR(8'h2C)
    ) u_b (
        .clk(clk), .rst(rst), .i_data(b_data), .i_valid(b_valid), .i_suppress(b_sup),
        .o_ready(b_ready), .o_tx_byte(b_byte), .o_tx_stb(b_stb),
        .i_tx_active(b_active), .o_idle(b_idle)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int seen_a = 0;
    int seen_b = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;

    // UART core model: is_transmitting rises the cycle after the strobe.
    assign a_active = a_hold | (a_busy != 0);
    assign b_active = (b_busy != 0);
    always @(posedge clk) begin
        if (rst) a_busy <= 0;
        else if (a_stb) a_busy <= BIT_CYC;
        else if (a_busy != 0) a_busy <= a_busy - 1;
        if (rst) b_busy <= 0;
        else if (b_stb) b_busy <= BIT_CYC;
        else if (b_busy != 0) b_busy <= b_busy - 1;
    end

    // Scoreboard: every strobe pops and compares one expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (a_stb) begin
            checks++;
            if (prev_a) begin errors++; $display("FAIL stb_gap_a: adjacent strobes, byte %02h", a_byte); end
            checks++;
            if (exp_a.size() == 0) begin
                errors++; $display("FAIL byte_a: got %02h, expected no byte", a_byte);
            end else begin
                e = exp_a.pop_front();
                if (a_byte !== e) begin errors++; $display("FAIL byte_a[%0d]: got %02h, expected %02h", seen_a, a_byte, e); end
            end
            seen_a++;
        end
        prev_a = a_stb;
        if (b_stb) begin
            checks++;
            if (prev_b) begin errors++; $display("FAIL stb_gap_b: adjacent strobes, byte %02h", b_byte); end
            checks++;
            if (exp_b.size() == 0) begin
                errors++; $display("FAIL byte_b: got %02h, expected no byte", b_byte);
            end else begin
                e = exp_b.pop_front();
                if (b_byte !== e) begin errors++; $display("FAIL byte_b[%0d]: got %02h, expected %02h", seen_b, b_byte, e); end
            end
            seen_b++;
        end
        prev_b = b_stb;
    end

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        return (v < 4'd10) ? 8'd48 + {4'h0, v} : 8'd55 + {4'h0, v};
    endfunction

    // Reference formatter: pushes the expected line for one record.
    task automatic push_model(input bit to_b, input logic [63:0] data, input int nf,
                              input int dw, input bit sup, input bit crlf, input logic [7:0] sep);
        logic [63:0] fv;
        logic [3:0]  nv;
        bit          started;
        logic [7:0]  line[$];
        for (int f = 0; f < nf; f++) begin
            fv = (data >> ((nf - 1 - f) * dw)) & ((64'd1 << dw) - 64'd1);
            started = !sup;
            for (int n = dw / 4 - 1; n >= 0; n--) begin
                nv = 4'(fv >> (n * 4));
                if (nv != 4'h0 || n == 0) started = 1'b1;
                if (started) line.push_back(hex_char(nv));
            end
            if (f != nf - 1) line.push_back(sep);
        end
        if (crlf) line.push_back(8'h0D);
        line.push_back(8'h0A);
        foreach (line[i]) begin
            if (to_b) exp_b.push_back(line[i]); else exp_a.push_back(line[i]);
        end
    endtask

    // Offer one record to A; returns #1 after the accepting edge.
    task automatic send_a(input logic [63:0] data, input bit sup);
        int t = 0;
        @(negedge clk);
        while (!a_ready && t < BUDGET) begin @(negedge clk); t++; end
        checks++;
        if (!a_ready) begin errors++; $display("FAIL send_a_ready: ready=%b after %0d cycles, expected 1", a_ready, t); end
        a_data = data; a_sup = sup; a_valid = 1'b1;
        push_model(1'b0, data, 2, 32, sup, 1'b1, 8'h20);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_drain_a(output bit ok);
        int t = 0;
        ok = 1'b0;
        while (t < BUDGET) begin
            @(negedge clk); #1; t++;
            if (exp_a.size() == 0 && a_idle) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_drain_b(output bit ok);
        int t = 0;
        ok = 1'b0;
        while (t < BUDGET) begin
            @(negedge clk); #1; t++;
            if (exp_b.size() == 0 && b_idle) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", a_ready); end
        checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b, expected 0", a_stb); end
        checks++; if (a_byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %02h, expected 00", a_byte); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b, expected 1", a_idle); end
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b, expected 1", b_ready); end
    endtask

    task automatic test_plain;
        int base = seen_a;
        bit ok;
        send_a(64'h0000_00AB_DEAD_BEEF, 1'b0);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b, expected 0", a_ready); end
        @(negedge clk);
        checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL latency_c1: stb=%b, expected 0", a_stb); end
        @(negedge clk);
        checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL latency_c2: stb=%b, expected 0", a_stb); end
        @(negedge clk);
        checks++; if (a_stb !== 1'b1) begin errors++; $display("FAIL latency_c3: stb=%b, expected 1", a_stb); end
        wait_drain_a(ok);
        checks++; if (!ok) begin errors++; $display("FAIL plain_drain: left %0d bytes, expected 0", exp_a.size()); end
        checks++; if (seen_a - base != 19) begin errors++; $display("FAIL plain_len: got %0d bytes, expected 19", seen_a - base); end
    endtask

    task automatic test_suppress;
        int base = seen_a;
        bit ok;
        send_a(64'h0000_00AB_DEAD_BEEF, 1'b1);
        wait_drain_a(ok);
        checks++; if (!ok || seen_a - base != 13) begin errors++; $display("FAIL sup_len: got %0d bytes ok=%b, expected 13", seen_a - base, ok); end
        base = seen_a;
        send_a(64'h0, 1'b1);
        wait_drain_a(ok);
        checks++; if (!ok || seen_a - base != 5) begin errors++; $display("FAIL zero_len: got %0d bytes ok=%b, expected 5", seen_a - base, ok); end
    endtask

    task automatic test_stall;
        int base = seen_a;
        bit ok;
        @(negedge clk);
        a_hold = 1'b1;
        send_a(64'h1234_5678_9ABC_DEF0, 1'b0);
        repeat (200) @(negedge clk);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b, expected 0", a_ready); end
        checks++; if (u_a.u_fifo.cnt !== 3'd4) begin errors++; $display("FAIL stall_full: cnt=%0d, expected 4", u_a.u_fifo.cnt); end
        checks++; if (seen_a != base) begin errors++; $display("FAIL stall_nostb: %0d bytes sent, expected 0", seen_a - base); end
        a_hold = 1'b0;
        wait_drain_a(ok);
        checks++; if (!ok || seen_a - base != 19) begin errors++; $display("FAIL stall_len: got %0d bytes ok=%b, expected 19", seen_a - base, ok); end
    endtask

    task automatic test_back_to_back;
        int base = seen_a;
        int t = 0;
        bit idle_early = 1'b0;
        bit idle_check_done = 1'b0;
        @(negedge clk);
        a_data = 64'h0000_00AB_DEAD_BEEF; a_sup = 1'b0; a_valid = 1'b1;
        push_model(1'b0, a_data, 2, 32, 1'b0, 1'b1, 8'h20);
        @(posedge clk); #1;
        a_data = 64'h0000_0010_00C0_FFEE; a_sup = 1'b1;
        push_model(1'b0, a_data, 2, 32, 1'b1, 1'b1, 8'h20);
        @(negedge clk);
        while (!a_ready && t < BUDGET) begin
            if (a_idle) idle_early = 1'b1;
            @(negedge clk); t++;
        end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b, expected 1", a_ready); end
        @(posedge clk); #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: ready=%b after rise, expected 0", a_ready); end
        a_valid = 1'b0;
        t = 0;
        while (t < BUDGET) begin
            @(negedge clk); #1; t++;
            if (a_idle && exp_a.size() != 0) idle_early = 1'b1;
            if (exp_a.size() == 0 && !idle_check_done) begin
                idle_check_done = 1'b1;
                checks++; if (a_idle !== 1'b0) begin errors++; $display("FAIL b2b_idle_last: idle=%b while last byte in flight, expected 0", a_idle); end
            end
            if (exp_a.size() == 0 && a_idle) break;
        end
        checks++; if (idle_early) begin errors++; $display("FAIL b2b_idle_early: idle=1 with bytes pending, expected 0"); end
        checks++; if (a_idle !== 1'b1 || seen_a - base != 30) begin errors++; $display("FAIL b2b_len: got %0d bytes idle=%b, expected 30 idle=1", seen_a - base, a_idle); end
    endtask

    task automatic test_reset_mid;
        int base = seen_a;
        int t = 0;
        bit ok;
        send_a(64'h0000_00AB_DEAD_BEEF, 1'b0);
        while (seen_a - base < 5 && t < BUDGET) begin @(negedge clk); #1; t++; end
        checks++; if (seen_a - base != 5) begin errors++; $display("FAIL mid_five: got %0d bytes, expected 5", seen_a - base); end
        rst = 1'b1;
        exp_a.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, expected 1", a_ready); end
        checks++; if (a_stb !== 1'b0) begin errors++; $display("FAIL mid_stb: got %b, expected 0", a_stb); end
        checks++; if (u_a.u_fifo.empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b, expected 1", u_a.u_fifo.empty); end
        base = seen_a;
        send_a(64'h0000_0001_0000_0002, 1'b0);
        wait_drain_a(ok);
        checks++; if (!ok || seen_a - base != 19) begin errors++; $display("FAIL mid_new_len: got %0d bytes ok=%b, expected 19", seen_a - base, ok); end
    endtask

    task automatic test_lf_single;
        int base = seen_b;
        bit ok;
        @(negedge clk);
        b_data = 8'h5C; b_sup = 1'b0; b_valid = 1'b1;
        push_model(1'b1, 64'h5C, 1, 8, 1'b0, 1'b0, 8'h2C);
        @(posedge clk); #1;
        b_valid = 1'b0;
        wait_drain_b(ok);
        checks++; if (!ok || seen_b - base != 3) begin errors++; $display("FAIL lf_len: got %0d bytes ok=%b, expected 3", seen_b - base, ok); end
    endtask

    initial begin
        test_reset();
        test_plain();
        test_suppress();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_lf_single();
        repeat (20) @(negedge clk);
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++; $display("FAIL leftover: a=%0d b=%0d bytes, expected 0", exp_a.size(), exp_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
